// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the pipelined MIPS core.
// Tracks in-flight register writes per post-decode stage, derives the decode
// stall and per-source forward selects, and owns the mult/div busy counter.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned TW     = 2,
  parameter int unsigned MD_LAT = 5,
  parameter int unsigned SELW   = 2   // 2**SELW must exceed DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              d_md_start,
  input  logic              flush,
  output logic              stall,
  output logic [SELW-1:0]   fwd_rs,
  output logic [SELW-1:0]   fwd_rt,
  output logic              md_busy
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  // Entry 0 is the E stage; higher indices are older stages.
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][REG_AW-1:0] r_dst;
  logic [DEPTH-1:0][TW-1:0]     r_tnew;
  logic [CW-1:0]                r_md_cnt;

  logic            w_rs_hit, w_rt_hit;
  logic [TW-1:0]   w_rs_tnew, w_rt_tnew;
  logic [SELW-1:0] w_rs_sel, w_rt_sel;
  logic            w_rs_haz, w_rt_haz, w_md_haz;
  logic            w_issue;

  // Find the youngest matching entry for rs; scanning old-to-young lets the
  // last (youngest) match overwrite any older one.
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rs_tnew = '0;
    w_rs_sel  = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (r_valid[k] && (r_dst[k] == d_rs) && (d_rs != '0)) begin
        w_rs_hit  = 1'b1;
        w_rs_tnew = r_tnew[k];
        w_rs_sel  = SELW'(k + 1);
      end
    end
  end

  // Same youngest-match search for rt.
  always_comb begin
    w_rt_hit  = 1'b0;
    w_rt_tnew = '0;
    w_rt_sel  = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (r_valid[k] && (r_dst[k] == d_rt) && (d_rt != '0)) begin
        w_rt_hit  = 1'b1;
        w_rt_tnew = r_tnew[k];
        w_rt_sel  = SELW'(k + 1);
      end
    end
  end

  // Hazard decisions and outputs, all combinational in the decode cycle.
  always_comb begin
    w_rs_haz = w_rs_hit && (w_rs_tnew > d_tuse_rs);
    w_rt_haz = w_rt_hit && (w_rt_tnew > d_tuse_rt);
    md_busy  = (r_md_cnt != '0);
    w_md_haz = d_md_use && md_busy;
    stall    = d_valid && (w_rs_haz || w_rt_haz || w_md_haz);
    // Forward only once the producer has its result (tnew == 0).
    fwd_rs   = (w_rs_hit && (w_rs_tnew == '0)) ? w_rs_sel : '0;
    fwd_rt   = (w_rt_hit && (w_rt_tnew == '0)) ? w_rt_sel : '0;
    w_issue  = d_valid && !stall && (d_dst != '0);
  end

  // Entry shift register: new issue (or bubble) enters at E, older entries
  // age by one stage with tnew counting down to zero; the oldest drops off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_dst   <= '0;
      r_tnew  <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_dst   <= '0;
      r_tnew  <= '0;
    end else begin
      r_valid[0] <= w_issue;
      r_dst[0]   <= w_issue ? d_dst  : '0;
      r_tnew[0]  <= w_issue ? d_tnew : '0;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_valid[k] <= r_valid[k-1];
        r_dst[k]   <= r_dst[k-1];
        r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
      end
    end
  end

  // Mult/div busy counter: loads on an accepted start, then counts down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt <= '0;
    end else if (flush) begin
      r_md_cnt <= '0;
    end else if (d_valid && d_md_start && !stall) begin
      r_md_cnt <= CW'(MD_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver pushes the hand-computed
// expected outputs for each cycle; a monitor pops and compares at negedge.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, d_md_start, flush;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
  logic       md_busy;

  typedef struct {
    logic       stall;
    logic [1:0] fr;
    logic [1:0] ft;
    logic       mb;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  hazard_scoreboard #(
    .REG_AW(5), .DEPTH(3), .TW(2), .MD_LAT(5), .SELW(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_dst     (d_dst),
    .d_tnew    (d_tnew),
    .d_md_use  (d_md_use),
    .d_md_start(d_md_start),
    .flush     (flush),
    .stall     (stall),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so one expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (stall !== e.stall || fwd_rs !== e.fr || fwd_rt !== e.ft || md_busy !== e.mb) begin
        errors = errors + 1;
        $display("FAIL %s: got stall=%b fwd_rs=%0d fwd_rt=%0d md_busy=%b, want stall=%b fwd_rs=%0d fwd_rt=%0d md_busy=%b",
                 e.name, stall, fwd_rs, fwd_rt, md_busy, e.stall, e.fr, e.ft, e.mb);
      end
    end
  end

  // One decode cycle: drive inputs just after posedge, queue the expectation.
  task automatic cyc(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] tur, input logic [1:0] tut, input logic [4:0] dst,
                     input logic [1:0] tn, input logic mu, input logic ms, input logic fl,
                     input logic es, input logic [1:0] efr, input logic [1:0] eft,
                     input logic emb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n    = rst;
    d_valid    = v;
    d_rs       = rs;
    d_rt       = rt;
    d_tuse_rs  = tur;
    d_tuse_rt  = tut;
    d_dst      = dst;
    d_tnew     = tn;
    d_md_use   = mu;
    d_md_start = ms;
    flush      = fl;
    e.stall = es;
    e.fr    = efr;
    e.ft    = eft;
    e.mb    = emb;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0;
    d_dst = '0; d_tnew = '0; d_md_use = 1'b0; d_md_start = 1'b0; flush = 1'b0;
    #12 reset_n = 1'b1;

    //  rst v  rs  rt  tur tut dst tn  mu ms fl | stall frs frt busy
    // lw -> use: tnew 2 against tuse 0
    cyc(1, 1, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0, 0, 0, 0, "lw_issue");
    cyc(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "lw_use_e");
    cyc(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "lw_use_m");
    cyc(1, 1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, "lw_use_w_fwd");
    // ALU -> use: tnew 1 against tuse 1
    cyc(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, "alu_issue");
    cyc(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "alu_use_e");
    cyc(1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, "alu_use_m_fwd");
    cyc(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, "alu_use_w_fwd");
    // Youngest match wins over older matches
    cyc(1, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, "yw_issue_a");
    cyc(1, 1, 0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, "yw_fwd_e");
    cyc(1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "yw_young_not_ready");
    cyc(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "yw_m_over_w");
    // Register $0 is never a hazard and never creates an entry
    cyc(1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, "zero_reg");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "zero_reg_after");
    // Mult/div busy window of exactly 5 cycles
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "md_start");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, "md_busy1_use");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "md_busy2_novalid");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "md_busy3_nouse");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, "md_busy4_restart_stalled");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "md_busy5");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "md_done_use");
    // Flush with three valid entries and counter at 3
    cyc(1, 1, 0, 0, 0, 0, 5, 3, 0, 1, 0, 0, 0, 0, 0, "fl_fill_a");
    cyc(1, 1, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0, 1, "fl_fill_b");
    cyc(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, "fl_fill_c");
    cyc(1, 1, 0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 1, "fl_flush_issue");
    cyc(1, 1, 7, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "fl_after");
    cyc(1, 1, 5, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "fl_after2");
    // Asynchronous reset mid-run with live entries and busy counter
    cyc(1, 1, 0, 0, 0, 0, 11, 2, 0, 1, 0, 0, 0, 0, 0, "rst_fill");
    cyc(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "rst_pre_stall");
    cyc(0, 1, 11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "rst_held");
    cyc(1, 1, 11, 11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "rst_released");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
